// File: rtl/priority_encoder_16x4_pipe.sv
// rtl/priority_encoder_16x4_pipe.sv - two-stage pipelined 16-to-4 highest-bit priority encoder
//
// Purpose:
//   Compresses a 16-bit request vector to the 4-bit index of its highest set
//   bit (a[15] wins). Stage 1 runs four 4x2 group encoders; stage 2 selects
//   the highest non-empty group. Both stages are registered, so y/any/multi
//   never depend combinationally on a.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request vector and enable present
//   in_ready   block can accept this cycle (combinational, from pipeline state)
//   a[15:0]    request vector
//   en         encoder enable, sampled with a
//   out_valid  result present
//   out_ready  downstream accepts result
//   y[3:0]     index of highest set bit of a
//   any        a had at least one bit set and en=1
//   multi      (only with PRIORITY_ENC_MULTIHOT_EN) en=1 and more than one bit of a set
//
// Build option:
//   PRIORITY_ENC_MULTIHOT_EN - adds the multi output and its per-group flags.

module priority_encoder_16x4_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic        en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  y,
    output logic        any
`ifdef PRIORITY_ENC_MULTIHOT_EN
    ,
    output logic        multi
`endif
);

    // 4x2 priority encoder: index of highest set bit, 0 when empty.
    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        if (v[3])      r = 2'd3;
        else if (v[2]) r = 2'd2;
        else if (v[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

`ifdef PRIORITY_ENC_MULTIHOT_EN
    // True when two or more of the four bits are set.
    function automatic logic more_than_one4(input logic [3:0] v);
        return (v[3] & (v[2] | v[1] | v[0])) |
               (v[2] & (v[1] | v[0])) |
               (v[1] & v[0]);
    endfunction
`endif

    // ---------------------------------------------------------------
    // Handshake / advance
    // ---------------------------------------------------------------
    logic       r_s1_valid;
    logic       r_out_valid;
    logic       w_s2_adv;
    logic       w_s1_adv;
    logic       w_in_xfer;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_in_xfer = in_valid && w_s1_adv;
    assign in_ready  = w_s1_adv;

    // ---------------------------------------------------------------
    // Stage 1: per-group encoders (combinational part)
    // ---------------------------------------------------------------
    logic [3:0] w_gv;
    logic [7:0] w_gi;
`ifdef PRIORITY_ENC_MULTIHOT_EN
    logic [3:0] w_gm;
`endif

    always_comb begin
        w_gv = 4'd0;
        w_gi = 8'd0;
`ifdef PRIORITY_ENC_MULTIHOT_EN
        w_gm = 4'd0;
`endif
        for (int g = 0; g < 4; g++) begin
            w_gv[g]       = |a[4*g +: 4];
            w_gi[2*g +: 2] = enc4(a[4*g +: 4]);
`ifdef PRIORITY_ENC_MULTIHOT_EN
            w_gm[g]       = more_than_one4(a[4*g +: 4]);
`endif
        end
    end

    // Stage-1 registers
    logic [3:0] r_gv;
    logic [7:0] r_gi;
    logic       r_en;
`ifdef PRIORITY_ENC_MULTIHOT_EN
    logic [3:0] r_gm;
`endif

    // ---------------------------------------------------------------
    // Stage 2: group select (combinational part)
    // ---------------------------------------------------------------
    logic [1:0] w_grp;
    logic [1:0] w_sub;
    logic       w_hit;

    // enc4 returns 0 for an empty vector; w_hit gates that case to y=0/any=0.
    assign w_grp = enc4(r_gv);
    assign w_sub = r_gi[2*w_grp +: 2];
    assign w_hit = r_en && (|r_gv);

`ifdef PRIORITY_ENC_MULTIHOT_EN
    logic w_multi;
    // Multi-hot if one group holds several bits or several groups are non-empty.
    assign w_multi = r_en && ((|r_gm) || more_than_one4(r_gv));
`endif

    // Output registers
    logic [3:0] r_y;
    logic       r_any;
`ifdef PRIORITY_ENC_MULTIHOT_EN
    logic       r_multi;
`endif

    // ---------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_gv        <= 4'd0;
            r_gi        <= 8'd0;
            r_en        <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= 4'd0;
            r_any       <= 1'b0;
`ifdef PRIORITY_ENC_MULTIHOT_EN
            r_gm        <= 4'd0;
            r_multi     <= 1'b0;
`endif
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_xfer) begin
                r_gv <= w_gv;
                r_gi <= w_gi;
                r_en <= en;
`ifdef PRIORITY_ENC_MULTIHOT_EN
                r_gm <= w_gm;
`endif
            end

            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid) begin
                if (w_hit) begin
                    r_y   <= {w_grp, w_sub};
                    r_any <= 1'b1;
                end else begin
                    r_y   <= 4'd0;
                    r_any <= 1'b0;
                end
`ifdef PRIORITY_ENC_MULTIHOT_EN
                r_multi <= w_multi;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign any       = r_any;
`ifdef PRIORITY_ENC_MULTIHOT_EN
    assign multi     = r_multi;
`endif

endmodule
